// File: rtl/opl3_pkg.sv
// Shared OPL3 constants: DAC output width and I2S serialiser defaults.
package opl3_pkg;

  localparam int unsigned DAC_OUTPUT_WIDTH = 16;
  localparam int unsigned I2S_SLOT_WIDTH   = 32;
  localparam int unsigned I2S_CLK_DIV      = 2;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_e;

endpackage

// File: rtl/i2s_sclk_gen.sv
// I2S bit-clock divider: registered sclk plus same-clk rise/fall strobes.
module i2s_sclk_gen
  import opl3_pkg::*;
#(
  parameter int unsigned CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("i2s_sclk_gen: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  assign tc = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    sclk_d    = sclk_q;
    if (tc) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  // Strobes flag the clk in which the registered sclk is about to toggle.
  assign sclk_o = sclk_q;
  assign rise_o = tc & ~sclk_q;
  assign fall_o = tc & sclk_q;

endmodule

// File: rtl/opl3_i2s_tx.sv
// Philips I2S transmitter: one-deep pending buffer, MSB-justified slots, underrun/overrun flags.
module opl3_i2s_tx
  import opl3_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DAC_OUTPUT_WIDTH,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int unsigned CLK_DIV    = I2S_CLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  output logic                i2s_sclk,
  output logic                i2s_ws,
  output logic                i2s_sd,
  output logic                underrun,
  output logic                overrun
);

  localparam int unsigned FRAME_W = 2 * SLOT_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  if (SAMPLE_W > SLOT_WIDTH) begin : g_bad_width
    $error("opl3_i2s_tx: SAMPLE_W must be <= SLOT_WIDTH");
  end

  logic sclk_rise, sclk_fall;

  i2s_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i  (clk),
    .rst_i  (reset),
    .sclk_o (i2s_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  pend_state_e         pend_q, pend_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                ws_q, ws_d, sd_q, sd_d;
  logic                under_q, under_d, over_q, over_d;
  logic                load;
  logic [CNT_W-1:0]    ws_idx;
  logic [FRAME_W-1:0]  frame;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    pend_d    = pend_q;
    pend_l_d  = pend_l_q;
    pend_r_d  = pend_r_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    under_d   = 1'b0;
    over_d    = 1'b0;
    load      = 1'b0;

    if (sclk_fall) begin
      bit_cnt_d = (bit_cnt_q == CNT_W'(FRAME_W - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
      load      = (bit_cnt_d == '0);
    end

    // The load reads the registered pending pair, so a coincident sample_valid
    // queues behind it instead of overwriting it.
    if (load) begin
      if (pend_q == PEND_FULL) begin
        hold_l_d = pend_l_q;
        hold_r_d = pend_r_q;
        pend_d   = PEND_EMPTY;
      end else begin
        under_d = 1'b1;
      end
    end else if (sample_valid && (pend_q == PEND_FULL)) begin
      over_d = 1'b1;
    end

    if (sample_valid) begin
      pend_l_d = sample_l;
      pend_r_d = sample_r;
      pend_d   = PEND_FULL;
    end

    frame  = {SLOT_WIDTH'(hold_l_d) << (SLOT_WIDTH - SAMPLE_W),
              SLOT_WIDTH'(hold_r_d) << (SLOT_WIDTH - SAMPLE_W)};
    ws_idx = (bit_cnt_d == CNT_W'(FRAME_W - 1)) ? '0 : bit_cnt_d + CNT_W'(1);

    if (sclk_fall) begin
      sd_d = frame[CNT_W'(FRAME_W - 1) - bit_cnt_d];
      ws_d = (ws_idx >= CNT_W'(SLOT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= CNT_W'(FRAME_W - 1);
      pend_q    <= PEND_EMPTY;
      pend_l_q  <= '0;
      pend_r_q  <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      pend_q    <= pend_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      ws_q      <= ws_d;
      sd_q      <= sd_d;
      under_q   <= under_d;
      over_q    <= over_d;
    end
  end

  assign i2s_ws   = ws_q;
  assign i2s_sd   = sd_q;
  assign underrun = under_q;
  assign overrun  = over_q;

  a_strobe_excl: assert property (@(posedge clk) !(sclk_rise && sclk_fall));

endmodule

// File: tb/tb_opl3_i2s_tx.sv
// Self-checking bench: an I2S receiver decodes frames against a scoreboard of expected pairs.
module tb_opl3_i2s_tx;

  localparam int unsigned SW = 16;
  localparam int unsigned SL = 32;
  localparam int unsigned CD = 2;
  localparam int NV = 8;
  localparam int NSWEEP = 150;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [SW-1:0] sample_l, sample_r;
  logic          i2s_sclk, i2s_ws, i2s_sd, underrun, overrun;

  opl3_i2s_tx #(.SAMPLE_W(SW), .SLOT_WIDTH(SL), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .i2s_sclk     (i2s_sclk),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  typedef struct packed {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } pair_t;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [SW-1:0] exp_l;
    logic [SW-1:0] exp_r;
  } vec_t;

  pair_t exp_q[$];
  vec_t  tbl[NV];

  int n_checks = 0;
  int n_fail   = 0;
  int n_under  = 0;
  int n_over   = 0;
  int cyc      = 0;
  int last_under = 0;
  int under_gap  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Flag monitor
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0) begin
      if (underrun) begin
        n_under++;
        under_gap  = cyc - last_under;
        last_under = cyc;
      end
      if (overrun) n_over++;
    end
  end

  // I2S receiver: sample sd/ws on sclk rise, slot ends at the rise where ws changes
  logic          rx_sclk_prev = 1'b0, rx_armed = 1'b0, rx_prev_ws = 1'b0;
  int            rx_bits = 0;
  logic [SL-1:0] rx_sr = '0;
  logic [SW-1:0] rx_l = '0;
  pair_t         rx_e;

  initial forever begin
    @(negedge clk);
    if (reset !== 1'b0) begin
      rx_armed = 1'b0; rx_bits = 0; rx_prev_ws = 1'b0; rx_sclk_prev = 1'b0;
    end else begin
      if (rx_sclk_prev && !i2s_sclk) rx_armed = 1'b1;
      else if (!rx_sclk_prev && i2s_sclk && rx_armed) begin
        rx_sr = {rx_sr[SL-2:0], i2s_sd};
        rx_bits++;
        if (i2s_ws != rx_prev_ws) begin
          chk(i2s_ws ? "left_slot_format" : "right_slot_format",
              {rx_bits, rx_sr[SL-SW-1:0]}, {32'd32, 16'h0000});
          if (i2s_ws) rx_l = rx_sr[SL-1:SL-SW];
          else if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_frame: got L=%h R=%h, expected no frame", rx_l, rx_sr[SL-1:SL-SW]);
          end else begin
            rx_e = exp_q.pop_front();
            chk("left_word", rx_l, rx_e.l);
            chk("right_word", rx_sr[SL-1:SL-SW], rx_e.r);
          end
          rx_bits = 0;
        end
        rx_prev_ws = i2s_ws;
      end
      rx_sclk_prev = i2s_sclk;
    end
  end

  task automatic pulse(input logic [SW-1:0] l, input logic [SW-1:0] r);
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_ws_edge(input logic to_val);
    logic p;
    p = i2s_ws;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (p != to_val && i2s_ws == to_val) return;
      p = i2s_ws;
    end
    n_checks++; n_fail++;
    $display("FAIL ws_edge_timeout: got no ws edge to %0d within 600 clk, expected one", to_val);
  endtask

  task automatic send_one(input logic [SW-1:0] l, input logic [SW-1:0] r,
                          input logic [SW-1:0] el, input logic [SW-1:0] er);
    exp_q.push_back('{el, er});
    pulse(l, r);
    wait_ws_edge(1'b0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int u0, o0, c;
    logic ps, found;
    logic [SW-1:0] rl, rr;

    tbl[0] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    tbl[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    tbl[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[4] = '{16'h0001, 16'hFFFE, 16'h0001, 16'hFFFE};
    tbl[5] = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    tbl[6] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    tbl[7] = '{16'h1357, 16'hECA8, 16'h1357, 16'hECA8};

    reset = 1'b1; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    repeat (3) @(negedge clk);
    chk("reset_sclk", i2s_sclk, 0);
    chk("reset_ws", i2s_ws, 0);
    chk("reset_sd", i2s_sd, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_overrun", overrun, 0);

    // First pair arrives before the first fall, so frame 0 carries it
    reset = 1'b0;
    exp_q.push_back('{16'h8001, 16'h7FFE});
    pulse(16'h8001, 16'h7FFE);
    repeat (10) @(negedge clk);

    for (int i = 0; i < NV; i++) send_one(tbl[i].l, tbl[i].r, tbl[i].exp_l, tbl[i].exp_r);
    chk("table_no_underrun", n_under, 0);
    chk("table_no_overrun", n_over, 0);

    // Starvation: last pair repeats with one underrun per frame
    u0 = n_under;
    repeat (3) begin
      exp_q.push_back('{tbl[NV-1].exp_l, tbl[NV-1].exp_r});
      wait_ws_edge(1'b0);
      repeat (8) @(negedge clk);
    end
    chk("underrun_count", n_under - u0, 3);
    chk("underrun_period", under_gap, 256);

    // Two pairs inside one frame: one overrun, second pair wins
    u0 = n_under; o0 = n_over;
    pulse(16'h1234, 16'h5678);
    repeat (20) @(negedge clk);
    exp_q.push_back('{16'h9ABC, 16'hDEF0});
    pulse(16'h9ABC, 16'hDEF0);
    repeat (4) @(negedge clk);
    chk("overrun_count", n_over - o0, 1);
    wait_ws_edge(1'b0);
    repeat (8) @(negedge clk);
    chk("overrun_no_underrun", n_under - u0, 0);

    // sample_valid in the load clk (4 clk after the ws fall)
    u0 = n_under; o0 = n_over;
    exp_q.push_back('{16'h0F0F, 16'hF0F0});
    pulse(16'h0F0F, 16'hF0F0);
    wait_ws_edge(1'b0);
    repeat (3) @(negedge clk);
    exp_q.push_back('{16'hC3C3, 16'h3C3C});
    pulse(16'hC3C3, 16'h3C3C);
    repeat (4) @(negedge clk);
    chk("coincident_no_overrun", n_over - o0, 0);
    chk("coincident_no_underrun", n_under - u0, 0);
    wait_ws_edge(1'b0);
    repeat (8) @(negedge clk);

    // Pair D is loaded next, then reset hits its right slot
    exp_q.push_back('{16'h4321, 16'h8765});
    pulse(16'h4321, 16'h8765);
    wait_ws_edge(1'b0);
    repeat (8) @(negedge clk);
    wait_ws_edge(1'b1);
    repeat (40) @(negedge clk);
    chk("pre_reset_ws_right", i2s_ws, 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_sclk", i2s_sclk, 0);
    chk("midreset_ws", i2s_ws, 0);
    chk("midreset_sd", i2s_sd, 0);
    @(negedge clk);

    u0 = n_under; o0 = n_over;
    reset = 1'b0;
    exp_q.push_back('{16'h5A5A, 16'hA5A5});
    sample_l = 16'h5A5A; sample_r = 16'hA5A5; sample_valid = 1'b1;
    ps = 1'b0; found = 1'b0; c = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      c++;
      #1;
      sample_valid = 1'b0;
      if (ps && !i2s_sclk) found = 1'b1;
      else ps = i2s_sclk;
    end
    chk("first_fall_after_reset", c, 4);
    @(negedge clk);

    for (int i = 0; i < NSWEEP; i++) begin
      rl = SW'($urandom);
      rr = SW'($urandom);
      send_one(rl, rr, rl, rr);
    end
    wait_ws_edge(1'b0);
    repeat (3) @(negedge clk);
    chk("sweep_no_underrun", n_under - u0, 0);
    chk("sweep_no_overrun", n_over - o0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
